// File: rtl/ps2_scancode_filter.sv
// Turns raw PS/2 Set 2 bytes into one-cycle make/break key events, suppressing
// typematic repeats, E0 fake shifts, status bytes and the Pause sequence.
module ps2_scancode_filter #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int ALLOW_REPEAT   = 0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_byte_valid,
    input  logic [7:0] ps2_byte,
    output logic       key_valid,
    output logic       key_release,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_held,
    output logic [7:0] dropped_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0_F0,
        SKIP_PAUSE
    } state_t;

    state_t          state, state_next;
    logic [TW-1:0]   timer, timer_next;
    logic [2:0]      skip, skip_next;
    logic            drop, do_make, do_break, ev_ext;
    logic [7:0]      held_code;
    logic            held_ext;
    logic            held_match, is_status, is_fake_shift;

    assign is_status     = ps2_byte inside {8'h00, 8'hAA, 8'hEE, 8'hFA,
                                            8'hFC, 8'hFD, 8'hFE, 8'hFF};
    assign is_fake_shift = (ps2_byte == 8'h12) || (ps2_byte == 8'h59);
    assign held_match    = key_held && (held_code == ps2_byte) && (held_ext == ev_ext);

    // A byte arriving on the expiry cycle is decoded in the current state.
    always_comb begin
        state_next = state;
        timer_next = timer;
        skip_next  = skip;
        drop       = 1'b0;
        do_make    = 1'b0;
        do_break   = 1'b0;
        ev_ext     = 1'b0;
        if (ps2_byte_valid) begin
            timer_next = '0;
            unique case (state)
                IDLE: begin
                    if (ps2_byte == 8'hE0) begin
                        state_next = GOT_E0;
                    end else if (ps2_byte == 8'hF0) begin
                        state_next = GOT_F0;
                    end else if (ps2_byte == 8'hE1) begin
                        state_next = SKIP_PAUSE;
                        skip_next  = 3'd7;
                    end else if (is_status) begin
                        drop = 1'b1;
                    end else begin
                        do_make = 1'b1;
                    end
                end
                GOT_E0: begin
                    state_next = IDLE;
                    ev_ext     = 1'b1;
                    if (ps2_byte == 8'hF0) begin
                        state_next = GOT_E0_F0;
                    end else if (is_fake_shift) begin
                        drop = 1'b1;
                    end else begin
                        do_make = 1'b1;
                    end
                end
                GOT_F0: begin
                    state_next = IDLE;
                    do_break   = 1'b1;
                end
                GOT_E0_F0: begin
                    state_next = IDLE;
                    ev_ext     = 1'b1;
                    if (is_fake_shift) begin
                        drop = 1'b1;
                    end else begin
                        do_break = 1'b1;
                    end
                end
                SKIP_PAUSE: begin
                    skip_next = skip - 3'd1;
                    if (skip == 3'd1) begin
                        state_next = IDLE;
                        drop       = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (state != IDLE) begin
            if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                state_next = IDLE;
                timer_next = '0;
                drop       = 1'b1;
            end else begin
                timer_next = timer + TW'(1);
            end
        end
    end

    // Registered event outputs; a make matching the held key is a typematic repeat.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            timer         <= '0;
            skip          <= '0;
            key_valid     <= 1'b0;
            key_release   <= 1'b0;
            key_code      <= '0;
            key_extended  <= 1'b0;
            key_held      <= 1'b0;
            held_code     <= '0;
            held_ext      <= 1'b0;
            dropped_count <= '0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            skip        <= skip_next;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            if (drop && (dropped_count != 8'hFF)) begin
                dropped_count <= dropped_count + 8'd1;
            end
            if (do_make && !(held_match && (ALLOW_REPEAT == 0))) begin
                key_valid    <= 1'b1;
                key_code     <= ps2_byte;
                key_extended <= ev_ext;
                held_code    <= ps2_byte;
                held_ext     <= ev_ext;
                key_held     <= 1'b1;
            end
            if (do_break) begin
                key_release  <= 1'b1;
                key_code     <= ps2_byte;
                key_extended <= ev_ext;
                if (held_match) begin
                    key_held <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_filter.sv
// Scoreboard bench: two filters (repeat suppressed / allowed) share one byte
// stream; a byte-level reference model predicts events, a monitor checks them.
module tb_ps2_scancode_filter;

    localparam int T = 20;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_in = 8'h00;

    logic       kv0, kr0, ke0, kh0, kv1, kr1, ke1, kh1;
    logic [7:0] kc0, dc0, kc1, dc1;

    ps2_scancode_filter #(.TIMEOUT_CYCLES(T), .ALLOW_REPEAT(0)) dut0 (
        .clk(clk), .resetn(resetn), .ps2_byte_valid(byte_valid), .ps2_byte(byte_in),
        .key_valid(kv0), .key_release(kr0), .key_code(kc0), .key_extended(ke0),
        .key_held(kh0), .dropped_count(dc0)
    );

    ps2_scancode_filter #(.TIMEOUT_CYCLES(T), .ALLOW_REPEAT(1)) dut1 (
        .clk(clk), .resetn(resetn), .ps2_byte_valid(byte_valid), .ps2_byte(byte_in),
        .key_valid(kv1), .key_release(kr1), .key_code(kc1), .key_extended(ke1),
        .key_held(kh1), .dropped_count(dc1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         rel;
        logic [7:0] code;
        bit         ext;
        bit         held;
        int         due;
    } ev_t;

    ev_t exp0[$];
    ev_t exp1[$];

    int checks = 0;
    int errors = 0;

    // Reference model: pending prefix flags, pause byte countdown, held key.
    bit         m_e0[2], m_f0[2], m_held[2], m_ext[2];
    logic [7:0] m_code[2];
    int         m_skip[2], m_drop[2];
    int         m_last = 0;

    function automatic int q_size(int m);
        return (m == 0) ? exp0.size() : exp1.size();
    endfunction

    function automatic ev_t q_pop(int m);
        if (m == 0) return exp0.pop_front();
        return exp1.pop_front();
    endfunction

    function automatic int q_front_due(int m);
        return (m == 0) ? exp0[0].due : exp1[0].due;
    endfunction

    function automatic void q_push(int m, ev_t e);
        if (m == 0) exp0.push_back(e);
        else exp1.push_back(e);
    endfunction

    function automatic void model_drop(int m);
        if (m_drop[m] < 255) m_drop[m]++;
    endfunction

    function automatic void model_make(int m, logic [7:0] code, bit ext, int due);
        ev_t e;
        if (m == 0 && m_held[m] && m_code[m] == code && m_ext[m] == ext) return;
        m_held[m] = 1; m_code[m] = code; m_ext[m] = ext;
        e.rel = 0; e.code = code; e.ext = ext; e.held = 1; e.due = due;
        q_push(m, e);
    endfunction

    function automatic void model_break(int m, logic [7:0] code, bit ext, int due);
        ev_t e;
        if (m_held[m] && m_code[m] == code && m_ext[m] == ext) m_held[m] = 0;
        e.rel = 1; e.code = code; e.ext = ext; e.held = m_held[m]; e.due = due;
        q_push(m, e);
    endfunction

    function automatic void model_byte(int m, logic [7:0] b, int c);
        bit fake;
        fake = (b == 8'h12) || (b == 8'h59);
        if ((m_e0[m] || m_f0[m] || m_skip[m] > 0) && (c - m_last > T)) begin
            model_drop(m);
            m_e0[m] = 0; m_f0[m] = 0; m_skip[m] = 0;
        end
        if (m_skip[m] > 0) begin
            m_skip[m]--;
            if (m_skip[m] == 0) model_drop(m);
        end else if (m_f0[m]) begin
            if (m_e0[m] && fake) model_drop(m);
            else model_break(m, b, m_e0[m], c);
            m_e0[m] = 0; m_f0[m] = 0;
        end else if (m_e0[m]) begin
            if (b == 8'hF0) begin
                m_f0[m] = 1;
            end else begin
                if (fake) model_drop(m);
                else model_make(m, b, 1, c);
                m_e0[m] = 0;
            end
        end else if (b == 8'hE0) begin
            m_e0[m] = 1;
        end else if (b == 8'hF0) begin
            m_f0[m] = 1;
        end else if (b == 8'hE1) begin
            m_skip[m] = 7;
        end else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF}) begin
            model_drop(m);
        end else begin
            model_make(m, b, 0, c);
        end
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_e0[m] = 0; m_f0[m] = 0; m_held[m] = 0; m_ext[m] = 0;
            m_code[m] = 8'h00; m_skip[m] = 0; m_drop[m] = 0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_dut(input int m, input logic kv, input logic kr, input logic [7:0] kc,
                             input logic ke, input logic kh);
        ev_t e;
        if (kv === 1'b1 || kr === 1'b1) begin
            checks++;
            if (q_size(m) == 0) begin
                errors++;
                $display("[TB] FAIL dut%0d unexpected_event cyc=%0d valid=%b release=%b code=%h",
                         m, cyc, kv, kr, kc);
            end else begin
                e = q_pop(m);
                if (kv !== !e.rel || kr !== e.rel || kc !== e.code || ke !== e.ext ||
                    kh !== e.held || cyc != e.due) begin
                    errors++;
                    $display("[TB] FAIL dut%0d event actual rel=%b/%b code=%h ext=%b held=%b cyc=%0d required rel=%b code=%h ext=%b held=%b cyc=%0d",
                             m, kv, kr, kc, ke, kh, cyc, e.rel, e.code, e.ext, e.held, e.due);
                end
            end
        end else if (q_size(m) > 0 && q_front_due(m) <= cyc) begin
            checks++;
            errors++;
            e = q_pop(m);
            $display("[TB] FAIL dut%0d missing_event actual=none required rel=%b code=%h ext=%b due=%0d",
                     m, e.rel, e.code, e.ext, e.due);
        end
    endtask

    // Monitor: samples one time unit after each active edge.
    always @(posedge clk) begin
        #1;
        check_dut(0, kv0, kr0, kc0, ke0, kh0);
        check_dut(1, kv1, kr1, kc1, ke1, kh1);
    end

    task automatic applyStimulus(input logic [7:0] b);
        int c;
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        c = cyc + 1;
        model_byte(0, b, c);
        model_byte(1, b, c);
        m_last = c;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag);
        idle(T + 3);
        for (int m = 0; m < 2; m++) begin
            if ((m_e0[m] || m_f0[m] || m_skip[m] > 0) && (cyc - m_last >= T)) begin
                model_drop(m);
                m_e0[m] = 0; m_f0[m] = 0; m_skip[m] = 0;
            end
        end
        check({tag, "_drop0"}, {24'h0, dc0}, m_drop[0]);
        check({tag, "_drop1"}, {24'h0, dc1}, m_drop[1]);
        check({tag, "_held0"}, {31'h0, kh0}, {31'h0, m_held[0]});
        check({tag, "_held1"}, {31'h0, kh1}, {31'h0, m_held[1]});
        check({tag, "_pending0"}, exp0.size(), 0);
        check({tag, "_pending1"}, exp1.size(), 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        byte_valid = 1'b0;
        resetn     = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        check({tag, "_valid"},    {31'h0, kv0}, 0);
        check({tag, "_release"},  {31'h0, kr0}, 0);
        check({tag, "_code"},     {24'h0, kc0}, 0);
        check({tag, "_extended"}, {31'h0, ke0}, 0);
        check({tag, "_held"},     {31'h0, kh0}, 0);
        check({tag, "_dropped"},  {24'h0, dc0}, 0);
        check({tag, "_dropped1"}, {24'h0, dc1}, 0);
    endtask

    task automatic send_seq(input logic [7:0] seq[$]);
        foreach (seq[i]) applyStimulus(seq[i]);
    endtask

    initial begin
        logic [7:0] b;
        int gap;
        model_reset();
        idle(3);
        do_reset("reset");

        send_seq('{8'h1C, 8'hF0, 8'h1C});
        checkOutput("press_release");

        send_seq('{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C});
        checkOutput("typematic");

        send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
        checkOutput("extended");
        send_seq('{8'hE0, 8'h12});
        checkOutput("fake_shift");
        check("fake_shift_count", {24'h0, dc0}, 1);

        send_seq('{8'hAA, 8'hFA, 8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29});
        checkOutput("status_pause");
        check("status_pause_count", {24'h0, dc0}, 4);

        applyStimulus(8'hF0);
        idle(T);
        applyStimulus(8'h1C);
        checkOutput("timeout_expired");
        applyStimulus(8'hF0);
        idle(T - 1);
        applyStimulus(8'h1C);
        checkOutput("timeout_edge");
        check("timeout_count", {24'h0, dc0}, 5);

        applyStimulus(8'hE0);
        do_reset("midseq_reset");
        applyStimulus(8'h75);
        checkOutput("after_reset");

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 11))
                0, 1:    b = 8'h1C;
                2, 3:    b = 8'hF0;
                4:       b = 8'hE0;
                5:       b = 8'h75;
                6:       b = 8'h12;
                7:       b = 8'h59;
                8:       b = 8'hAA;
                9:       b = 8'hE1;
                10:      b = 8'h29;
                default: b = 8'($urandom_range(0, 255));
            endcase
            applyStimulus(b);
            gap = $urandom_range(0, 19);
            if (gap < 12)       gap = 0;
            else if (gap < 16)  gap = $urandom_range(1, 3);
            else if (gap == 16) gap = T - 1;
            else if (gap == 17) gap = T;
            else if (gap == 18) gap = T + 2;
            else                gap = 0;
            if (gap > 0) idle(gap);
            if (i % 50 == 49) checkOutput("random");
        end
        checkOutput("random_end");

        for (int i = 0; i < 270; i++) applyStimulus(8'hAA);
        checkOutput("saturate");
        check("saturate_ff", {24'h0, dc0}, 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
